// File: rtl/ue14500_seq.sv
// ue14500_seq: program sequencer between program memory and the 1-bit ICU.
// Optional call/return stack enabled by defining UE14500_SEQ_CALL_STACK_EN.
module ue14500_seq #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter bit                START_RUN   = 1'b1,
  parameter int                STACK_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [3:0]        MEM_OP,
  input  logic [ADDR_W-1:0] MEM_OPND,
  input  logic              FL0,
  input  logic              JMP,
  input  logic              RTN,
  input  logic              FLF,
  input  logic              RUN_REQ,
  input  logic              STEP_REQ,
  input  logic              HALT_REQ,
  output logic [ADDR_W-1:0] ADDR,
  output logic [3:0]        IR_OUT,
  output logic              RUNNING,
  output logic              STK_ERR
);

  typedef enum logic [1:0] {S_RUN, S_STEP, S_DRAIN, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] opnd_q, opnd_d;
  logic [ADDR_W-1:0] rtn_pc;
  logic              flags_live, jmp_take, rtn_take;

  // Flags always belong to the previously issued instruction; after a bubble
  // (STEP, HALT) there is nothing to act on.
  assign flags_live = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign jmp_take   = flags_live && JMP;
  assign rtn_take   = flags_live && !JMP && RTN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= START_RUN ? S_RUN : S_HALT;
      pc_q    <= RESET_VEC;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      opnd_q  <= opnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    opnd_d  = opnd_q;
    case (state_q)
      S_RUN: begin
        opnd_d = MEM_OPND;
        if (FLF || HALT_REQ) state_d = S_DRAIN;
      end
      S_STEP: begin
        opnd_d  = MEM_OPND;
        pc_d    = pc_q + 1'b1;
        state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_HALT;
      S_HALT: begin
        if (RUN_REQ)       state_d = S_RUN;
        else if (STEP_REQ) state_d = S_STEP;
      end
      default: state_d = S_HALT;
    endcase
    if (jmp_take)                pc_d = opnd_q;
    else if (rtn_take)           pc_d = rtn_pc;
    else if (state_q == S_RUN)   pc_d = pc_q + 1'b1;
  end

  assign ADDR    = pc_q;
  assign IR_OUT  = (state_q == S_RUN || state_q == S_STEP) ? MEM_OP : 4'hF;
  assign RUNNING = (state_q == S_RUN);

`ifdef UE14500_SEQ_CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] stk_q [STACK_DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d, sp_m1;
  logic              prefix_q, prefix_d, err_q, err_d, push;

  assign sp_m1 = sp_q - 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sp_q     <= '0;
      prefix_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sp_q     <= sp_d;
      prefix_q <= prefix_d;
      err_q    <= err_d;
    end
  end

  // Entries need no reset: sp alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) stk_q[sp_q[IDX_W-1:0]] <= pc_q + 1'b1;
  end

  always_comb begin
    sp_d     = sp_q;
    prefix_d = prefix_q;
    err_d    = err_q;
    push     = 1'b0;
    rtn_pc   = RESET_VEC;
    if (state_q == S_RUN) prefix_d = FL0;
    // A JMP preceded by NOP0 is a call; pc+1 skips past the delay slot.
    if (jmp_take && prefix_q) begin
      if (sp_q == SP_FULL) begin
        err_d = 1'b1;
      end else begin
        push = 1'b1;
        sp_d = sp_q + 1'b1;
      end
    end else if (rtn_take) begin
      if (sp_q == '0) begin
        err_d = 1'b1;
      end else begin
        sp_d   = sp_m1;
        rtn_pc = stk_q[sp_m1[IDX_W-1:0]];
      end
    end
  end

  assign STK_ERR = err_q;
`else
  logic unused_fl0;
  assign unused_fl0 = FL0;
  assign rtn_pc     = RESET_VEC;
  assign STK_ERR    = 1'b0;
`endif

endmodule

// File: tb/tb_ue14500_seq.sv
// Bench for ue14500_seq: directed scenarios plus randomized programs checked
// against a behavioural sequencer model and a tiny ICU flag model.
module tb_ue14500_seq;

`ifdef UE14500_SEQ_CALL_STACK_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif
  localparam int        DEPTH = 4;
  localparam logic [7:0] RV   = 8'h00;
  localparam int M_RUN = 0, M_STEP = 1, M_DRAIN = 2, M_HALT = 3;

  logic       CLK = 1'b0, RST = 1'b1;
  logic [3:0] MEM_OP;
  logic [7:0] MEM_OPND;
  logic       FL0 = 0, JMP = 0, RTN = 0, FLF = 0;
  logic       RUN_REQ = 0, STEP_REQ = 0, HALT_REQ = 0;
  logic [7:0] ADDR;
  logic [3:0] IR_OUT;
  logic       RUNNING, STK_ERR;

  logic [3:0] mem_op   [256];
  logic [7:0] mem_opnd [256];

  int n_cmp = 0, n_err = 0;

  // reference model state
  int         md;
  logic [7:0] m_pc, m_opnd;
  bit         m_pfx, m_err, icu_skip;
  logic [7:0] m_stk [$];

  assign MEM_OP   = mem_op[ADDR];
  assign MEM_OPND = mem_opnd[ADDR];

  always #5 CLK = ~CLK;

  ue14500_seq #(.ADDR_W(8), .RESET_VEC(8'h00), .START_RUN(1'b1), .STACK_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .MEM_OP(MEM_OP), .MEM_OPND(MEM_OPND),
    .FL0(FL0), .JMP(JMP), .RTN(RTN), .FLF(FLF),
    .RUN_REQ(RUN_REQ), .STEP_REQ(STEP_REQ), .HALT_REQ(HALT_REQ),
    .ADDR(ADDR), .IR_OUT(IR_OUT), .RUNNING(RUNNING), .STK_ERR(STK_ERR)
  );

  task automatic load_fill();
    for (int a = 0; a < 256; a++) begin
      mem_op[a]   = 4'h1;
      mem_opnd[a] = 8'h00;
    end
  endtask

  task automatic model_reset();
    md = M_RUN; m_pc = RV; m_opnd = 8'h00; m_pfx = 0; m_err = 0; icu_skip = 0;
    m_stk.delete();
    FL0 = 0; JMP = 0; RTN = 0; FLF = 0;
    RUN_REQ = 0; STEP_REQ = 0; HALT_REQ = 0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // One clock edge: the model decides the next state from the present inputs,
  // and the ICU stand-in raises flags for whatever was actually issued.
  task automatic tick();
    int nmd;
    logic [7:0] npc, nopnd, nxt;
    logic [3:0] op;
    bit npfx, nerr, issued, nj, nr, nf, n0, nskip;
    issued = (md == M_RUN || md == M_STEP);
    op = mem_op[m_pc];
    nxt = m_pc + 8'd1;
    nmd = md; npc = m_pc; nopnd = m_opnd; npfx = m_pfx; nerr = m_err;
    if (md == M_RUN || md == M_DRAIN) begin
      if (JMP) begin
        if (FEAT && m_pfx) begin
          if (m_stk.size() >= DEPTH) nerr = 1;
          else m_stk.push_back(nxt);
        end
        npc = m_opnd;
      end else if (RTN) begin
        if (!FEAT) npc = RV;
        else if (m_stk.size() == 0) begin npc = RV; nerr = 1; end
        else npc = m_stk.pop_back();
      end else if (md == M_RUN) npc = nxt;
    end
    case (md)
      M_RUN: begin
        nopnd = mem_opnd[m_pc];
        if (FEAT) npfx = FL0;
        if (FLF || HALT_REQ) nmd = M_DRAIN;
      end
      M_STEP:  begin nopnd = mem_opnd[m_pc]; npc = nxt; nmd = M_DRAIN; end
      M_DRAIN: nmd = M_HALT;
      default: if (RUN_REQ) nmd = M_RUN; else if (STEP_REQ) nmd = M_STEP;
    endcase
    nj = 0; nr = 0; nf = 0; n0 = 0; nskip = 0;
    if (issued && !icu_skip) begin
      nj = (op == 4'hC); nr = (op == 4'hD); nf = (op == 4'hF); n0 = (op == 4'h0);
      nskip = nr;
    end
    @(posedge CLK);
    #1;
    md = nmd; m_pc = npc; m_opnd = nopnd; m_pfx = npfx; m_err = nerr; icu_skip = nskip;
    JMP = nj; RTN = nr; FLF = nf; FL0 = n0;
    RUN_REQ = 0; STEP_REQ = 0; HALT_REQ = 0;
  endtask

  task automatic test_reset();
    load_fill();
    mem_op[0] = 4'h7;
    RST = 1'b1;
    model_reset();
    #2;
    n_cmp++;
    if (ADDR !== 8'h00 || RUNNING !== 1'b1 || IR_OUT !== 4'h7 || STK_ERR !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: addr=%h run=%b ir=%h err=%b, want 00 1 7 0", ADDR, RUNNING, IR_OUT, STK_ERR);
    end
    @(negedge CLK); RST = 1'b0;
    repeat (3) tick();
    RST = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if (ADDR !== 8'h00 || RUNNING !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: addr=%h run=%b, want 00 1", ADDR, RUNNING);
    end
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_run();
    load_fill();
    mem_op[0] = 4'h1; mem_op[1] = 4'h2; mem_op[2] = 4'h4;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if (ADDR !== 8'(i) || RUNNING !== 1'b1 || IR_OUT !== mem_op[i]) begin
        n_err++;
        $display("FAIL run_seq%0d: addr=%h run=%b ir=%h, want %h 1 %h", i, ADDR, RUNNING, IR_OUT, 8'(i), mem_op[i]);
      end
    end
  endtask

  task automatic test_jump();
    load_fill();
    mem_op[5] = 4'hC; mem_opnd[5] = 8'h20; mem_op[6] = 4'h2;
    do_reset();
    repeat (6) tick();
    n_cmp++;
    if (ADDR !== 8'h06 || IR_OUT !== 4'h2) begin
      n_err++;
      $display("FAIL jump_delay_slot: addr=%h ir=%h, want 06 2", ADDR, IR_OUT);
    end
    tick();
    n_cmp++;
    if (ADDR !== 8'h20) begin
      n_err++;
      $display("FAIL jump_target: addr=%h, want 20", ADDR);
    end
  endtask

  task automatic test_halt();
    load_fill();
    mem_op[3] = 4'hF; mem_op[5] = 4'h3;
    do_reset();
    repeat (5) tick();
    n_cmp++;
    if (ADDR !== 8'h05 || RUNNING !== 1'b0 || IR_OUT !== 4'hF) begin
      n_err++;
      $display("FAIL halt_drain: addr=%h run=%b ir=%h, want 05 0 f", ADDR, RUNNING, IR_OUT);
    end
    repeat (3) begin HALT_REQ = 1; tick(); end
    n_cmp++;
    if (ADDR !== 8'h05 || RUNNING !== 1'b0 || IR_OUT !== 4'hF) begin
      n_err++;
      $display("FAIL halt_hold: addr=%h run=%b ir=%h, want 05 0 f", ADDR, RUNNING, IR_OUT);
    end
    RUN_REQ = 1; tick();
    n_cmp++;
    if (ADDR !== 8'h05 || RUNNING !== 1'b1 || IR_OUT !== 4'h3) begin
      n_err++;
      $display("FAIL halt_resume: addr=%h run=%b ir=%h, want 05 1 3", ADDR, RUNNING, IR_OUT);
    end
    tick();
    n_cmp++;
    if (ADDR !== 8'h06) begin
      n_err++;
      $display("FAIL halt_resume_adv: addr=%h, want 06", ADDR);
    end
  endtask

  task automatic test_step();
    load_fill();
    mem_op[3] = 4'hF; mem_op[5] = 4'h3;
    do_reset();
    repeat (6) tick();
    STEP_REQ = 1; tick();
    n_cmp++;
    if (ADDR !== 8'h05 || IR_OUT !== 4'h3 || RUNNING !== 1'b0) begin
      n_err++;
      $display("FAIL step_issue: addr=%h ir=%h run=%b, want 05 3 0", ADDR, IR_OUT, RUNNING);
    end
    tick();
    n_cmp++;
    if (ADDR !== 8'h06 || IR_OUT !== 4'hF) begin
      n_err++;
      $display("FAIL step_drain: addr=%h ir=%h, want 06 f", ADDR, IR_OUT);
    end
    tick(); tick();
    n_cmp++;
    if (ADDR !== 8'h06 || IR_OUT !== 4'hF || RUNNING !== 1'b0) begin
      n_err++;
      $display("FAIL step_halt: addr=%h ir=%h run=%b, want 06 f 0", ADDR, IR_OUT, RUNNING);
    end
    STEP_REQ = 1; RUN_REQ = 1; tick();
    n_cmp++;
    if (RUNNING !== 1'b1 || ADDR !== 8'h06) begin
      n_err++;
      $display("FAIL step_run_prio: run=%b addr=%h, want 1 06", RUNNING, ADDR);
    end
  endtask

  task automatic test_call_return();
    load_fill();
    mem_op[8'h00] = 4'hC; mem_opnd[8'h00] = 8'h10;
    mem_op[8'h10] = 4'h0;
    mem_op[8'h11] = 4'hC; mem_opnd[8'h11] = 8'h40;
    mem_op[8'h41] = 4'hD;
    do_reset();
    repeat (4) tick();
    n_cmp++;
    if (ADDR !== 8'h12) begin
      n_err++;
      $display("FAIL call_delay_slot: addr=%h, want 12", ADDR);
    end
    tick();
    n_cmp++;
    if (ADDR !== 8'h40) begin
      n_err++;
      $display("FAIL call_target: addr=%h, want 40", ADDR);
    end
    repeat (3) tick();
    n_cmp++;
    if (ADDR !== (FEAT ? 8'h13 : RV) || STK_ERR !== 1'b0) begin
      n_err++;
      $display("FAIL call_return: addr=%h err=%b, want %h 0", ADDR, STK_ERR, FEAT ? 8'h13 : RV);
    end
  endtask

  task automatic test_stack_errors();
    bit hit;
    load_fill();
    mem_op[0] = 4'hD;
    do_reset();
    tick(); tick();
    n_cmp++;
    if (ADDR !== RV || STK_ERR !== FEAT) begin
      n_err++;
      $display("FAIL rtn_empty: addr=%h err=%b, want %h %b", ADDR, STK_ERR, RV, FEAT);
    end
    load_fill();
    mem_op[0] = 4'hC; mem_opnd[0] = 8'h50;
    for (int k = 0; k < 5; k++) begin
      mem_op[8'h50 + 4*k]   = 4'h0;
      mem_op[8'h51 + 4*k]   = 4'hC;
      mem_opnd[8'h51 + 4*k] = (k < 4) ? 8'(8'h54 + 4*k) : 8'h70;
    end
    do_reset();
    hit = 0;
    for (int c = 0; c < 60 && !hit; c++) begin
      tick();
      if (ADDR === 8'h70) hit = 1;
    end
    n_cmp++;
    if (!hit || STK_ERR !== FEAT) begin
      n_err++;
      $display("FAIL stack_overflow: reached70=%b err=%b, want 1 %b", hit, STK_ERR, FEAT);
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_ir;
    for (int a = 0; a < 256; a++) begin
      int r;
      r = $urandom_range(0, 99);
      mem_op[a] = (r < 8) ? 4'hC : (r < 12) ? 4'hD : (r < 15) ? 4'hF :
                  (r < 24) ? 4'h0 : 4'($urandom_range(1, 11));
      mem_opnd[a] = 8'($urandom);
    end
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      RUN_REQ  = ($urandom_range(0, 99) < 30);
      STEP_REQ = ($urandom_range(0, 99) < 25);
      HALT_REQ = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 599) == 0) do_reset();
      else tick();
      exp_ir = (md == M_RUN || md == M_STEP) ? mem_op[m_pc] : 4'hF;
      n_cmp++;
      if ({ADDR, IR_OUT, RUNNING, STK_ERR} !== {m_pc, exp_ir, md == M_RUN, m_err}) begin
        n_err++;
        $display("FAIL random_c%0d: addr=%h ir=%h run=%b err=%b, want %h %h %b %b",
                 c, ADDR, IR_OUT, RUNNING, STK_ERR, m_pc, exp_ir, md == M_RUN, m_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_jump();
    test_halt();
    test_step();
    test_call_return();
    test_stack_errors();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
